// File: rtl/wb_stage_pipe.sv
// Purpose: MEM/WB pipeline register; aligns and extends load data, selects write-back source, counts retires.
// Latency: 1 cycle from sampled inputs to every output; all outputs come straight from flops.
// Backpressure: stall holds all state (load_err clears); flush or missing valid_in inserts a bubble.
module wb_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         wb_sel,
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lsb,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic [XLEN-1:0]    alu_out,
    input  logic [XLEN-1:0]    pc_plus4,
    input  logic [XLEN-1:0]    csr_rdata,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               reg_wr_en,
    output logic [XLEN-1:0]    wb_data,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_we,
    output logic               wb_valid,
    output logic               load_err,
    output logic [CNT_W-1:0]   instret
);

    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_ALU  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [31:0]        word_lane;
    logic [XLEN-1:0]    load_val;
    logic               load_bad;
    logic [XLEN-1:0]    sel_val;

    logic [XLEN-1:0]    wb_data_q,  wb_data_d;
    logic [RADDR_W-1:0] wb_rd_q,    wb_rd_d;
    logic               wb_we_q,    wb_we_d;
    logic               wb_valid_q, wb_valid_d;
    logic               load_err_q, load_err_d;
    logic [CNT_W-1:0]   instret_q,  instret_d;

    // Extract the addressed byte/half from the low word and extend to XLEN.
    always_comb begin
        word_lane = dmem_rdata[31:0];
        case (addr_lsb)
            2'd0:    byte_lane = word_lane[7:0];
            2'd1:    byte_lane = word_lane[15:8];
            2'd2:    byte_lane = word_lane[23:16];
            default: byte_lane = word_lane[31:24];
        endcase
        half_lane = addr_lsb[1] ? word_lane[31:16] : word_lane[15:0];
        case (funct3)
            F3_LB:   load_val = XLEN'($signed(byte_lane));
            F3_LH:   load_val = XLEN'($signed(half_lane));
            F3_LBU:  load_val = XLEN'(byte_lane);
            F3_LHU:  load_val = XLEN'(half_lane);
            default: load_val = XLEN'($signed(word_lane));
        endcase
    end

    // Flag misaligned halves/words and reserved load encodings, only when load data is selected.
    always_comb begin
        load_bad = 1'b0;
        if (wb_sel == SEL_LOAD) begin
            case (funct3)
                F3_LH, F3_LHU: load_bad = addr_lsb[0];
                F3_LW:         load_bad = (addr_lsb != 2'b00);
                F3_LB, F3_LBU: load_bad = 1'b0;
                default:       load_bad = 1'b1;
            endcase
        end
    end

    // Four-way write-back source mux.
    always_comb begin
        case (wb_sel)
            SEL_LOAD: sel_val = load_val;
            SEL_ALU:  sel_val = alu_out;
            SEL_PC4:  sel_val = pc_plus4;
            default:  sel_val = csr_rdata;
        endcase
    end

    // Next-state: flush beats stall; an idle, unstalled cycle is a bubble; load_err never lingers.
    always_comb begin
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_we_d    = wb_we_q;
        wb_valid_d = wb_valid_q;
        load_err_d = 1'b0;
        instret_d  = instret_q;
        if (flush || (!stall && !valid_in)) begin
            wb_we_d    = 1'b0;
            wb_valid_d = 1'b0;
        end else if (!stall) begin
            wb_data_d  = sel_val;
            wb_rd_d    = rd_addr;
            wb_valid_d = 1'b1;
            wb_we_d    = reg_wr_en && (rd_addr != '0) && !load_bad;
            load_err_d = load_bad;
            if (!load_bad) begin
                instret_d = instret_q + CNT_W'(1);
            end
        end
    end

    // MEM/WB register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            load_err_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            wb_valid_q <= wb_valid_d;
            load_err_q <= load_err_d;
            instret_q  <= instret_d;
        end
    end

    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_we    = wb_we_q;
    assign wb_valid = wb_valid_q;
    assign load_err = load_err_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  addr_lsb = '0;
    logic [31:0] dmem_rdata = '0, alu_out = '0, pc_plus4 = '0, csr_rdata = '0;
    logic [4:0]  rd_addr = '0;
    logic        reg_wr_en = 1'b0;

    logic [31:0] wb_data, wb_data4;
    logic [4:0]  wb_rd, wb_rd4;
    logic        wb_we, wb_valid, load_err, wb_we4, wb_valid4, load_err4;
    logic [63:0] instret;
    logic [3:0]  instret4;

    always #5 clk = ~clk;

    wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .wb_sel(wb_sel), .funct3(funct3), .addr_lsb(addr_lsb), .dmem_rdata(dmem_rdata),
        .alu_out(alu_out), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata), .rd_addr(rd_addr),
        .reg_wr_en(reg_wr_en), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_valid(wb_valid), .load_err(load_err), .instret(instret));

    wb_stage_pipe #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
        .wb_sel(wb_sel), .funct3(funct3), .addr_lsb(addr_lsb), .dmem_rdata(dmem_rdata),
        .alu_out(alu_out), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata), .rd_addr(rd_addr),
        .reg_wr_en(reg_wr_en), .wb_data(wb_data4), .wb_rd(wb_rd4), .wb_we(wb_we4),
        .wb_valid(wb_valid4), .load_err(load_err4), .instret(instret4));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we, valid, lerr, dchk;
        logic [63:0] cnt;
    } exp_t;

    exp_t m;
    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lsb)) & 32'hFF;
        h = (w >> (16 * (lsb / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Drive one cycle's inputs (caller is already at a falling edge) and queue the expected state.
    task automatic apply(input bit v, input bit s, input bit f, input bit [1:0] sel,
                         input bit [2:0] f3, input bit [1:0] lsb, input bit [31:0] rdat,
                         input bit [31:0] alu, input bit [31:0] pc, input bit [31:0] csr,
                         input bit [4:0] rd, input bit we);
        bit err;
        valid_in = v; stall = s; flush = f; wb_sel = sel; funct3 = f3; addr_lsb = lsb;
        dmem_rdata = rdat; alu_out = alu; pc_plus4 = pc; csr_rdata = csr;
        rd_addr = rd; reg_wr_en = we;
        if (f || (!s && !v)) begin
            m.valid = 0; m.we = 0; m.lerr = 0;
        end else if (s) begin
            m.lerr = 0;
        end else begin
            err = (sel == 0) && ((f3 == 3) || (f3 == 6) || (f3 == 7) ||
                  (((f3 == 1) || (f3 == 5)) && (lsb % 2 == 1)) || ((f3 == 2) && (lsb != 0)));
            case (sel)
                2'd0: m.data = ref_load(f3, lsb, rdat);
                2'd1: m.data = alu;
                2'd2: m.data = pc;
                default: m.data = csr;
            endcase
            m.dchk  = !((sel == 0) && ((f3 == 3) || (f3 == 6) || (f3 == 7)));
            m.rd    = rd;
            m.valid = 1;
            m.we    = we && (rd != 0) && !err;
            m.lerr  = err;
            if (!err) m.cnt = m.cnt + 1;
        end
        q.push_back(m);
    endtask

    task automatic cyc(input bit v, input bit s, input bit f, input bit [1:0] sel,
                       input bit [2:0] f3, input bit [1:0] lsb, input bit [31:0] rdat,
                       input bit [31:0] alu, input bit [31:0] pc, input bit [31:0] csr,
                       input bit [4:0] rd, input bit we);
        @(negedge clk);
        rst_n = 1'b1;
        apply(v, s, f, sel, f3, lsb, rdat, alu, pc, csr, rd, we);
    endtask

    task automatic rnd_cyc(input bit s);
        cyc(1'b1, s, 1'b0, 2'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
            $urandom, $urandom, 5'($urandom), 1'($urandom));
    endtask

    // Assert reset between edges and check that every output clears without a clock.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_instret", instret, 0);
        chk("rst_instret4", instret4, 0);
        m = '{data: 0, rd: 0, we: 0, valid: 0, lerr: 0, dchk: 1, cnt: 0};
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wb_valid", wb_valid, e.valid);
                chk("wb_we", wb_we, e.we);
                chk("load_err", load_err, e.lerr);
                chk("wb_rd", wb_rd, e.rd);
                if (e.dchk) chk("wb_data", wb_data, e.data);
                chk("instret", instret, e.cnt);
                chk("instret4", instret4, e.cnt % 16);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        bit [4:0] rd;
        m = '{data: 0, rd: 0, we: 0, valid: 0, lerr: 0, dchk: 1, cnt: 0};
        #2;
        do_reset();

        // Load extraction from 0x8899AABB.
        cyc(1, 0, 0, 2'b00, 3'b000, 2'b01, 32'h8899AABB, 0, 0, 0, 5'd3, 1);
        cyc(1, 0, 0, 2'b00, 3'b100, 2'b11, 32'h8899AABB, 0, 0, 0, 5'd3, 1);
        cyc(1, 0, 0, 2'b00, 3'b001, 2'b10, 32'h8899AABB, 0, 0, 0, 5'd3, 1);
        cyc(1, 0, 0, 2'b00, 3'b101, 2'b00, 32'h8899AABB, 0, 0, 0, 5'd3, 1);
        cyc(1, 0, 0, 2'b00, 3'b010, 2'b00, 32'h8899AABB, 0, 0, 0, 5'd3, 1);

        // Non-load sources, then an x0 destination.
        cyc(1, 0, 0, 2'b01, 3'b010, 2'b00, 0, 32'h11, 32'h104, 32'h5A, 5'd7, 1);
        cyc(1, 0, 0, 2'b10, 3'b010, 2'b00, 0, 32'h11, 32'h104, 32'h5A, 5'd7, 1);
        cyc(1, 0, 0, 2'b11, 3'b010, 2'b00, 0, 32'h11, 32'h104, 32'h5A, 5'd7, 1);
        cyc(1, 0, 0, 2'b01, 3'b010, 2'b00, 0, 32'h11, 32'h104, 32'h5A, 5'd0, 1);

        // Load errors, each separated by a bubble and back-to-back.
        cyc(1, 0, 0, 2'b00, 3'b010, 2'b10, 32'h12345678, 0, 0, 0, 5'd4, 1);
        cyc(0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 5'd0, 0);
        cyc(1, 0, 0, 2'b00, 3'b001, 2'b01, 32'h12345678, 0, 0, 0, 5'd4, 1);
        cyc(1, 0, 0, 2'b00, 3'b011, 2'b00, 32'h12345678, 0, 0, 0, 5'd4, 1);
        cyc(1, 0, 0, 2'b01, 3'b011, 2'b00, 0, 32'h33, 0, 0, 5'd4, 1);

        // Errored load followed by a stall: the pulse must not repeat.
        cyc(1, 0, 0, 2'b00, 3'b110, 2'b00, 0, 0, 0, 0, 5'd9, 1);
        rnd_cyc(1'b1);

        // Accept 0x22 to x5, stall three cycles on fresh inputs, then flush while stalled.
        cyc(1, 0, 0, 2'b01, 3'b000, 2'b00, 0, 32'h22, 0, 0, 5'd5, 1);
        repeat (3) rnd_cyc(1'b1);
        cyc(1, 1, 1, 2'b01, 3'b000, 2'b00, 0, 32'h77, 0, 0, 5'd6, 1);
        cyc(0, 1, 0, 2'b01, 3'b000, 2'b00, 0, 32'h78, 0, 0, 5'd6, 1);

        // Reset while wb_we is high and a stall is pending.
        cyc(1, 0, 0, 2'b01, 3'b000, 2'b00, 0, 32'hABCD, 0, 0, 5'd8, 1);
        do_reset();

        // Seventeen retires so the 4-bit counter wraps.
        for (int i = 0; i < 17; i++) begin
            rd = 5'(i + 1);
            cyc(1, 0, 0, 2'b01, 3'b000, 2'b00, 0, 32'(i * 3), 0, 0, rd, 1);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 8) == 0,
                2'($urandom), ($urandom % 2) ? 3'($urandom) : 3'(($urandom % 2) ? 2 : 0),
                2'($urandom), $urandom, $urandom, $urandom, $urandom,
                ($urandom % 6 == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
            if (i == 1500) do_reset();
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Registered write-back stage for the RV32I pipeline: captures the MEM-stage result bundle into the MEM/WB register, aligns and sign/zero-extends load data, selects among four write-back sources, and drives the register-file write port one cycle later. Supports stall (hold) and flush (bubble), flags misaligned or illegal loads, and keeps a retired-instruction counter. It replaces the combinational write-back select and feeds both the register file and the forwarding unit.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64; byte/half/word extraction always uses the low 32 bits of dmem_rdata)
- RADDR_W, 5, register address width
- CNT_W, 64, retire counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  MEM stage holds a real instruction
- stall  in  1  hold all stage registers
- flush  in  1  squash incoming instruction
- wb_sel  in  2  00 load data, 01 ALU, 10 PC+4, 11 CSR read data
- funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- addr_lsb  in  2  effective address bits [1:0]
- dmem_rdata  in  XLEN  raw word from data memory
- alu_out  in  XLEN  ALU result
- pc_plus4  in  XLEN  link value
- csr_rdata  in  XLEN  CSR read value
- rd_addr  in  RADDR_W  destination register
- reg_wr_en  in  1  instruction writes rd
- wb_data  out  XLEN  registered write-back data
- wb_rd  out  RADDR_W  registered destination
- wb_we  out  1  register-file write enable
- wb_valid  out  1  stage holds a retiring instruction
- load_err  out  1  one-cycle pulse: misaligned/illegal load squashed
- instret  out  CNT_W  retired instruction count

## Operation
- Accept condition: acc = valid_in & !stall & !flush.
- Load alignment (combinational, before register): byte lane = dmem_rdata[8*addr_lsb +: 8]; half lane = dmem_rdata[16*addr_lsb[1] +: 16]; LB/LH sign-extend to XLEN, LBU/LHU zero-extend, LW passes dmem_rdata[31:0] sign-extended to XLEN.
- Load error when wb_sel==00 and: LH/LHU with addr_lsb[0]=1; LW with addr_lsb!=00; funct3 in {011,110,111}.
- Source select: 00 aligned load, 01 alu_out, 10 pc_plus4, 11 csr_rdata.
- On acc: wb_data <= selected value; wb_rd <= rd_addr; wb_valid <= 1; wb_we <= reg_wr_en & (rd_addr!=0) & !err; load_err <= err; instret <= instret+1 only if !err.
- flush (any stall value): wb_valid, wb_we, load_err <= 0; wb_data, wb_rd hold. Flush has priority over stall.
- stall & !flush: all registers hold, except load_err <= 0 (pulse never repeats).
- !valid_in & !stall & !flush: bubble, same as flush.
- x0 writes never asserted; wb_data still captured.
- instret wraps modulo 2^CNT_W; errored loads do not retire.

## Timing
- Latency 1: inputs sampled at edge N appear on all outputs after edge N.
- rst_n low: immediately wb_data=0, wb_rd=0, wb_we=0, wb_valid=0, load_err=0, instret=0, independent of clk. Reset mid-stall or mid-flush discards everything; first accept after release is at first rising edge with rst_n high.
- No combinational path from any input to any output.
- Stall of k cycles holds wb_we high for k+1 cycles if set; register file rewrites identical value (harmless).
- load_err high exactly one cycle per errored instruction.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle with wb_we=1 -> all outputs 0 immediately, instret=0.
- Load extraction: dmem_rdata=0x8899AABB; LB lsb=01 -> 0xFFFFFFAA; LBU lsb=11 -> 0x00000088; LH lsb=10 -> 0xFFFF8899; LHU lsb=00 -> 0x0000AABB; LW -> 0x8899AABB; each one cycle later, wb_we=1, instret +1 each.
- Sources: wb_sel 01/10/11 with alu_out=0x11, pc_plus4=0x104, csr_rdata=0x5A -> wb_data 0x11, 0x104, 0x5A on successive cycles; rd_addr=0 -> wb_we=0, wb_valid=1.
- Load errors: LW lsb=10, LH lsb=01, funct3=011 -> load_err single-cycle pulse each, wb_we=0, instret unchanged.
- Stall/flush: accept ALU 0x22 to x5, stall 3 cycles with new inputs -> outputs hold 0x22/x5/we=1 for 4 cycles; assert flush with stall=1 -> next cycle wb_valid=0, wb_we=0.
- Counter wrap: CNT_W=4, retire 17 instructions -> instret 0,1,...,15,0,1.
